mac_sample_source: RTL and testbench

Transmit-side stream source for the sum-of-squares accumulator. It buffers 8-bit samples written by a host or bench into a small FIFO, then drives them onto the accumulator's `valid`/`a` input stream. Samples go out in programmable bursts separated by programmable idle gaps, which exercises the accumulator's hold-on-invalid behaviour. It sits directly upstream of the accumulator; its `valid_out`/`a_out` connect to the accumulator's `valid_in`/`a`.

---
 rtl/mac_src_pkg.sv | 13 +
 rtl/mac_sample_source_if.sv | 11 +
 rtl/sample_fifo.sv | 62 ++++++
 rtl/mac_sample_source.sv | 114 +++++++++++
 tb/tb_mac_sample_source.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_src_pkg.sv
// rtl/mac_src_pkg.sv - shared types and widths for the accumulator sample source
package mac_src_pkg;

    localparam int SAMPLE_W = 8;
    localparam int LEN_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_sample_source_if.sv
// rtl/mac_sample_source_if.sv - valid/sample stream toward the accumulator
interface mac_sample_source_if;
    import mac_src_pkg::*;

    logic                valid_out;
    logic [SAMPLE_W-1:0] a_out;

    modport master (output valid_out, output a_out);
    modport slave  (input  valid_out, input  a_out);

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with combinational head
module sample_fifo
    import mac_src_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                full,
    output logic                empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                wr_ok;
    logic                rd_ok;

    // full/empty come from the pre-update count, so a write while full is never rescued by a same-cycle pop
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_sample_source.sv
// rtl/mac_sample_source.sv - bursty sample stream source feeding the accumulator
module mac_sample_source
    import mac_src_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                enable,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [LEN_W-1:0]    gap_len,
    output logic                full,
    output logic                empty,
    output logic                busy,
    output logic [CNT_W-1:0]    sent_count,
    output logic                overflow_err,
    mac_sample_source_if.master src
);

    state_t              state;
    logic [LEN_W-1:0]    burst_cfg;
    logic [LEN_W-1:0]    burst_cnt;
    logic [LEN_W-1:0]    burst_cnt_nxt;
    logic [LEN_W-1:0]    gap_cfg;
    logic [LEN_W-1:0]    gap_cnt;
    logic [SAMPLE_W-1:0] head;
    logic                pop;

    // A disable takes priority over popping so the leaving cycle emits nothing
    assign pop           = (state == SEND) && enable && !empty;
    assign burst_cnt_nxt = burst_cnt + 1'b1;
    assign busy          = (state != IDLE);

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Burst/gap FSM with registered stream outputs and sample counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            burst_cfg     <= '0;
            burst_cnt     <= '0;
            gap_cfg       <= '0;
            gap_cnt       <= '0;
            src.valid_out <= 1'b0;
            src.a_out     <= '0;
            sent_count    <= '0;
            overflow_err  <= 1'b0;
        end else begin
            src.valid_out <= 1'b0;
            if (wr_en && full) begin
                overflow_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= SEND;
                        burst_cfg <= burst_len;
                        burst_cnt <= '0;
                        gap_cfg   <= gap_len;
                    end
                end
                SEND: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (pop) begin
                        src.valid_out <= 1'b1;
                        src.a_out     <= head;
                        sent_count    <= sent_count + 1'b1;
                        if (burst_cfg != '0 && burst_cnt_nxt == burst_cfg) begin
                            if (gap_cfg == '0) begin
                                burst_cnt <= '0;
                                burst_cfg <= burst_len;
                                gap_cfg   <= gap_len;
                            end else begin
                                state     <= GAP;
                                burst_cnt <= burst_cnt_nxt;
                                gap_cnt   <= gap_cfg;
                            end
                        end else begin
                            burst_cnt <= burst_cnt_nxt;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gap_cnt == 8'd1) begin
                        state     <= SEND;
                        burst_cnt <= '0;
                        burst_cfg <= burst_len;
                        gap_cfg   <= gap_len;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sample_source.sv
// tb/tb_mac_sample_source.sv - vector and sequence bench for mac_sample_source
module tb_mac_sample_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        enable;
    logic [7:0]  burst_len;
    logic [7:0]  gap_len;
    logic        full;
    logic        empty;
    logic        busy;
    logic [15:0] sent_count;
    logic        overflow_err;

    int n_applied = 0;
    int n_miss    = 0;

    mac_sample_source_if s_if ();

    mac_sample_source #(.DEPTH(16), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .enable       (enable),
        .burst_len    (burst_len),
        .gap_len      (gap_len),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .sent_count   (sent_count),
        .overflow_err (overflow_err),
        .src          (s_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [7:0]  wd;
        logic        en;
        logic [7:0]  bl;
        logic [7:0]  gl;
        logic        ev;
        logic [7:0]  ea;
        logic [15:0] ec;
        logic        ee;
        logic        ef;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic wr, input logic [7:0] wd, input logic en,
                       input logic [7:0] bl, input logic [7:0] gl, input logic ev, input logic [7:0] ea,
                       input logic [15:0] ec, input logic ee, input logic ef, input logic eb);
        vec_t v;
        v = '{rst, wr, wd, en, bl, gl, ev, ea, ec, ee, ef, eb};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic wr, input logic [7:0] wd, input logic en,
                         input logic [7:0] bl, input logic [7:0] gl);
        reset = rst; wr_en = wr; wr_data = wd; enable = en; burst_len = bl; gap_len = gl;
    endtask

    function automatic logic [31:0] outs();
        return {4'd0, s_if.valid_out, s_if.a_out, sent_count, empty, full, busy};
    endfunction

    logic [31:0] acc_f;
    logic [31:0] acc_exp [5];
    logic [11:0] vpat;
    int          k;

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_state", outs(), {4'd0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0});
        chk("reset_ovf", {31'd0, overflow_err}, 32'd0);

        // basic stream, write-to-output latency, then bursts with gaps
        add(0, 1, 21, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0, 1, 36, 1, 0, 0,  0, 0, 0,  0, 0, 1);
        add(0, 0, 0,  1, 0, 0,  1, 21, 1, 0, 0, 1);
        add(0, 0, 0,  1, 0, 0,  1, 36, 2, 1, 0, 1);
        add(0, 0, 0,  1, 0, 0,  0, 36, 2, 1, 0, 1);
        add(0, 1, 50, 1, 0, 0,  0, 36, 2, 0, 0, 1);
        add(0, 0, 0,  1, 0, 0,  1, 50, 3, 1, 0, 1);
        add(1, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 1, 8'(i), 0, 3, 2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3, 2,  0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 1, 1,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 2, 2,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 3, 3,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 3, 3,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 3, 3,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 4, 4,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 5, 5,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 6, 6,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 6, 6,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 6, 6,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 7, 7,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 8, 8,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 9, 9,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 9, 9,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  0, 9, 9,  0, 0, 1);
        add(0, 0, 0, 1, 3, 2,  1, 10, 10, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].en, vecs[i].bl, vecs[i].gl);
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {4'd0, vecs[i].ev, vecs[i].ea, vecs[i].ec, vecs[i].ee, vecs[i].ef, vecs[i].eb});
        end

        // full FIFO and overflow
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 8'(100 + i), 0, 0, 0); tick();
        end
        chk("full_after_16", {31'd0, full}, 32'd1);
        chk("ovf_before_17", {31'd0, overflow_err}, 32'd0);
        drive(0, 1, 200, 0, 0, 0); tick();
        chk("ovf_after_17", {31'd0, overflow_err}, 32'd1);
        drive(0, 0, 0, 1, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("full_drain%0d", i), {23'd0, s_if.valid_out, s_if.a_out}, {23'd0, 1'b1, 8'(100 + i)});
        end
        tick();
        chk("full_drain_end", {30'd0, s_if.valid_out, empty}, {30'd0, 1'b0, 1'b1});
        chk("full_count", {16'd0, sent_count}, 32'd16);
        chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);

        // disable mid-burst, then fresh burst on re-enable
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'(31 + i), 0, 4, 1); tick();
        end
        drive(0, 0, 0, 1, 4, 1); tick();
        tick();
        tick();
        chk("dis_second", {23'd0, s_if.valid_out, s_if.a_out}, {23'd0, 1'b1, 8'd32});
        drive(0, 0, 0, 0, 4, 1); tick();
        chk("dis_off", {22'd0, s_if.valid_out, s_if.a_out, busy}, {22'd0, 1'b0, 8'd32, 1'b0});
        drive(0, 0, 0, 1, 4, 1); tick();
        chk("dis_reenter", {30'd0, s_if.valid_out, busy}, {30'd0, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("dis_burst%0d", i), {23'd0, s_if.valid_out, s_if.a_out}, {23'd0, 1'b1, 8'(33 + i)});
        end
        tick();
        chk("dis_gap", {31'd0, s_if.valid_out}, 32'd0);

        // reset mid-burst discards queued samples
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 8'(60 + i), 0, 0, 0); tick();
        end
        drive(0, 0, 0, 1, 0, 0); tick();
        tick();
        tick();
        drive(1, 0, 0, 1, 0, 0); tick();
        chk("rst_mid", outs(), {4'd0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0});
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst_quiet%0d", i), {29'd0, s_if.valid_out, empty, busy}, {29'd0, 1'b0, 1'b1, 1'b1});
        end

        // accumulator model fed by the stream
        acc_exp[0] = 441; acc_exp[1] = 1737; acc_exp[2] = 5833; acc_exp[3] = 5833; acc_exp[4] = 70858;
        vpat  = 12'b110011001000;
        acc_f = 0;
        k     = 0;
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 21, 0, 2, 2); tick();
        drive(0, 1, 36, 0, 2, 2); tick();
        drive(0, 1, 64, 0, 2, 2); tick();
        drive(0, 1, 0, 0, 2, 2); tick();
        drive(0, 1, 255, 0, 2, 2); tick();
        drive(0, 0, 0, 1, 2, 2); tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("acc_valid%0d", i), {31'd0, s_if.valid_out}, {31'd0, vpat[11 - i]});
            if (s_if.valid_out === 1'b1 && k < 5) begin
                acc_f = acc_f + 32'(s_if.a_out) * 32'(s_if.a_out);
                chk($sformatf("acc_f%0d", k), acc_f, acc_exp[k]);
                k++;
            end
        end
        chk("acc_samples", 32'(k), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
